// File: rtl/mux_4_1_scanner_if.sv
// ---------------------------------------------------------------------------
// mux_4_1_scanner_if
// Bundles the scan-control and frame-handshake signals of mux_4_1_scanner.
//
// Signals
//   start        request one scan of all four mux channels (to scanner)
//   y            output of the downstream 4:1 mux being scanned (to scanner)
//   frame_ready  consumer accepts the frame together with frame_valid
//   s1, s0       mux select MSB / LSB (from scanner, registered)
//   busy         scan in progress (from scanner)
//   frame        captured frame, bit n = y sampled while {s1,s0}=n
//   frame_valid  frame complete and stable (from scanner)
//
// Modports
//   master  environment side: drives start/y/frame_ready
//   slave   scanner side: drives selects, busy and the frame
// ---------------------------------------------------------------------------
interface mux_4_1_scanner_if;
    logic       start;
    logic       y;
    logic       frame_ready;
    logic       s1;
    logic       s0;
    logic       busy;
    logic [3:0] frame;
    logic       frame_valid;

    modport master (
        output start, y, frame_ready,
        input  s1, s0, busy, frame, frame_valid
    );

    modport slave (
        input  start, y, frame_ready,
        output s1, s0, busy, frame, frame_valid
    );
endinterface

// File: rtl/mux_4_1_scanner.sv
// ---------------------------------------------------------------------------
// mux_4_1_scanner
// Steps the select lines of an external 4:1 mux through channels 0..3,
// holds each select for DWELL cycles, samples the mux output on the last
// dwell cycle of each channel and presents the four samples as a frame
// with a valid/ready handshake.
//
// Parameters
//   DWELL   cycles each select is held before sampling (legal 1..255)
//
// Ports
//   clk     single clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     mux_4_1_scanner_if.slave (start, y, frame_ready in;
//           s1, s0, busy, frame, frame_valid out, all registered)
//
// Configuration macro
//   SCAN_CONTINUOUS_EN  when defined, an accepted frame immediately starts
//                       the next scan; otherwise the block returns to IDLE
//                       and waits for a new start.
// ---------------------------------------------------------------------------
module mux_4_1_scanner #(
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_4_1_scanner_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Dwell counter reload value; counting runs DWELL-1 down to 0 so each
    // channel occupies exactly DWELL cycles.
    localparam logic [7:0] RELOAD = 8'(DWELL - 1);

    state_t     r_state;
    logic [1:0] r_channel;
    logic [7:0] r_count;
    logic [3:0] r_frame;
    logic       r_s1;
    logic       r_s0;
    logic       r_busy;
    logic       r_valid;

    state_t     w_state_nxt;
    logic [1:0] w_channel_nxt;
    logic [7:0] w_count_nxt;
    logic [3:0] w_frame_nxt;
    logic       w_s1_nxt;
    logic       w_s0_nxt;
    logic       w_busy_nxt;
    logic       w_valid_nxt;

    // Next-state, channel/counter sequencing and frame capture.
    always_comb begin
        w_state_nxt   = r_state;
        w_channel_nxt = r_channel;
        w_count_nxt   = r_count;
        w_frame_nxt   = r_frame;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = SETTLE;
                    w_channel_nxt = 2'd0;
                    w_count_nxt   = RELOAD;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            SETTLE: begin
                if (r_count != 8'd0) begin
                    w_count_nxt = r_count - 8'd1;
                end else begin
                    // Last dwell cycle: the select has been stable for DWELL
                    // cycles, so y now reflects this channel.
                    w_frame_nxt[r_channel] = bus.y;
                    if (r_channel != 2'd3) begin
                        w_channel_nxt = r_channel + 2'd1;
                        w_count_nxt   = RELOAD;
                    end else begin
                        // Channel 3 ends the scan rather than wrapping.
                        w_state_nxt   = DONE;
                        w_channel_nxt = 2'd0;
                        w_count_nxt   = 8'd0;
                    end
                end
            end
            DONE: begin
                if (bus.frame_ready) begin
`ifdef SCAN_CONTINUOUS_EN
                    w_state_nxt   = SETTLE;
                    w_channel_nxt = 2'd0;
                    w_count_nxt   = RELOAD;
`else
                    w_state_nxt   = IDLE;
`endif
                end else begin
                    w_state_nxt   = DONE;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_channel_nxt = 2'd0;
                w_count_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are derived from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        w_s1_nxt    = 1'b0;
        w_s0_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        case (w_state_nxt)
            SETTLE: begin
                w_s1_nxt   = w_channel_nxt[1];
                w_s0_nxt   = w_channel_nxt[0];
                w_busy_nxt = 1'b1;
            end
            DONE: begin
                w_valid_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, sequencing and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_channel <= 2'd0;
            r_count   <= 8'd0;
            r_frame   <= 4'b0000;
            r_s1      <= 1'b0;
            r_s0      <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_channel <= w_channel_nxt;
            r_count   <= w_count_nxt;
            r_frame   <= w_frame_nxt;
            r_s1      <= w_s1_nxt;
            r_s0      <= w_s0_nxt;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign bus.s1          = r_s1;
    assign bus.s0          = r_s0;
    assign bus.busy        = r_busy;
    assign bus.frame       = r_frame;
    assign bus.frame_valid = r_valid;

endmodule

// File: tb/tb_mux_4_1_scanner.sv
// ---------------------------------------------------------------------------
// tb_mux_4_1_scanner
// Drives mux_4_1_scanner with a behavioural 4:1 mux and randomized scans.
// A reference model predicts outputs every cycle from scan position
// arithmetic; accepted starts push the expected frame and completion cycle
// into a scoreboard that is popped whenever frame_valid rises.
// ---------------------------------------------------------------------------
module tb_mux_4_1_scanner;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] mux_in = 4'b0000;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    typedef struct {
        logic [3:0] frame;
        int         due;
    } exp_t;
    exp_t q[$];

    // Reference model: phase 0 idle, 1 scanning (k edges since start), 2 done
    int         ph = 0;
    int         k = 0;
    logic [3:0] scan_in = 4'b0000;
    logic [3:0] base = 4'b0000;
    logic [3:0] m_frame = 4'b0000;
    logic       prev_valid = 1'b0;

    mux_4_1_scanner_if sif();

    assign sif.y = mux_in[{sif.s1, sif.s0}];

    mux_4_1_scanner #(.DWELL(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model_out();
        logic [3:0] f;
        logic [1:0] sel;
        case (ph)
            1: begin
                sel = 2'(k / D);
                f = base;
                for (int n = 0; n < 4; n++)
                    if (k >= (n + 1) * D) f[n] = scan_in[n];
                return {sel, 1'b1, 1'b0, f};
            end
            2: return {2'b00, 1'b0, 1'b1, m_frame};
            default: return {2'b00, 1'b0, 1'b0, m_frame};
        endcase
    endfunction

    // Monitor: per-cycle output check, scoreboard pop, then model advance.
    always @(negedge clk) begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        exp_t e;
        if (!rst_n) begin
            ph = 0; k = 0; m_frame = 4'b0000; base = 4'b0000;
            q.delete();
        end
        exp_v = model_out();
        act_v = {sif.s1, sif.s0, sif.busy, sif.frame_valid, sif.frame};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL outputs cyc=%0d {s1s0,busy,valid,frame} actual=%b required=%b",
                     cyc, act_v, exp_v);
        end
        if (sif.frame_valid === 1'b1 && !prev_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame cyc=%0d frame=%b required=no frame", cyc, sif.frame);
            end else begin
                e = q.pop_front();
                if (sif.frame !== e.frame || cyc != e.due) begin
                    bad++;
                    $display("FAIL frame_pop actual frame=%b cyc=%0d required frame=%b cyc=%0d",
                             sif.frame, cyc, e.frame, e.due);
                end
            end
        end
        prev_valid = (sif.frame_valid === 1'b1);
        if (rst_n) begin
            case (ph)
                0: if (sif.start === 1'b1) begin
                    ph = 1; k = 0; scan_in = mux_in; base = m_frame;
                    q.push_back('{mux_in, cyc + 1 + 4 * D});
                end
                1: begin
                    k++;
                    if (k == 4 * D) begin
                        ph = 2; m_frame = scan_in;
                    end
                end
                2: if (sif.frame_ready === 1'b1) begin
`ifdef SCAN_CONTINUOUS_EN
                    ph = 1; k = 0; scan_in = mux_in; base = m_frame;
                    q.push_back('{mux_in, cyc + 1 + 4 * D});
`else
                    ph = 0;
`endif
                end
                default: ph = 0;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_zero(input string name);
        logic [7:0] act_v;
        act_v = {sif.s1, sif.s0, sif.busy, sif.frame_valid, sif.frame};
        total++;
        if (act_v !== 8'd0) begin
            bad++;
            $display("FAIL %s actual=%b required=00000000", name, act_v);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic begin_scan(input logic [3:0] data);
`ifdef SCAN_CONTINUOUS_EN
        if (sif.busy || sif.frame_valid) reset_pulse();
`else
        int n = 0;
        while ((sif.busy || sif.frame_valid) && n < 200) begin
            step(1);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL idle_timeout actual=busy required=idle within 200 cycles");
        end
`endif
        mux_in = data;
        sif.start = 1'b1;
        step(1);
        sif.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!sif.frame_valid && n < budget) begin
            step(1);
            n++;
        end
        total++;
        if (!sif.frame_valid) begin
            bad++;
            $display("FAIL valid_timeout actual=no frame_valid required=within %0d cycles", budget);
        end
    endtask

    initial begin
        sif.start = 1'b0;
        sif.frame_ready = 1'b0;
        // Reset asserted mid-cycle must clear outputs without a clock.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_state");
        step(1);
        rst_n = 1'b1;
        step(10);

        // Reference scan: a,b,c,d = 1,0,1,1 -> frame 4'b1101.
        sif.frame_ready = 1'b1;
        begin_scan(4'b1101);
        wait_valid(4 * D + 5);
        step(3);

        // Consumer stalls; start pulses during the scan and in DONE.
        sif.frame_ready = 1'b0;
        begin_scan(4'($urandom));
        step(3);
        sif.start = 1'b1;
        step(1);
        sif.start = 1'b0;
        wait_valid(4 * D + 5);
        sif.start = 1'b1;
        step(1);
        sif.start = 1'b0;
        step(4);
        sif.frame_ready = 1'b1;
        step(1);
        sif.frame_ready = 1'b0;

        // Randomized scans with random start noise and ready delay.
        for (int i = 0; i < 8; i++) begin
            sif.frame_ready = 1'b0;
            begin_scan(4'($urandom));
            repeat (4 * D - 1) begin
                sif.start = 1'($urandom_range(0, 1));
                step(1);
            end
            sif.start = 1'b0;
            wait_valid(8);
            repeat ($urandom_range(0, 3)) begin
                sif.start = 1'($urandom_range(0, 1));
                step(1);
            end
            sif.start = 1'b0;
            sif.frame_ready = 1'b1;
            step(1);
            sif.frame_ready = 1'b0;
        end

        // Reset while channel 2 is selected abandons the scan.
        sif.frame_ready = 1'b0;
        begin_scan(4'b1010);
        step(2 * D + 1);
        reset_pulse();
        step(10);
        sif.frame_ready = 1'b1;
        begin_scan(4'b0110);
        wait_valid(4 * D + 5);
        step(2);

        // Ready held high: back-to-back frames or a single frame.
        sif.frame_ready = 1'b1;
        begin_scan(4'b0011);
        step(40);
        sif.frame_ready = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
